// File: rtl/grant_data_mux_pkg.sv
// Shared types and helpers for the grant-to-FIFO consumer stage.
package grant_data_mux_pkg;

    localparam int NUM_CH = 4;
    localparam int SRC_W  = 2;

    typedef logic [SRC_W-1:0] src_t;

    // Lowest set bit wins when more than one bit is set.
    function automatic src_t onehot_idx(input logic [NUM_CH-1:0] v);
        src_t idx;
        idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (v[i]) idx = src_t'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/grant_mux_fifo.sv
// Synchronous FIFO with head output masked to zero while empty.
module grant_mux_fifo #(
    parameter int W     = 10,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (do_pop && !do_push)
                count <= count - 1'b1;
        end
    end

    // Storage is not reset; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    assign head = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/grant_data_mux.sv
// Grant decode, payload mux and output FIFO behind the round-robin arbiter.
// Optional one-hot checking: GRANT_DATA_MUX_ONEHOT_CHECK_EN.
module grant_data_mux
    import grant_data_mux_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        grants,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    output logic                     accepted,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [SRC_W-1:0]         out_src,
    output logic                     err
);

    localparam int FW = DATA_W + SRC_W;

    logic              gnt_any;
    logic              gnt_ok;
    src_t              gnt_idx;
    logic [DATA_W-1:0] gnt_data;
    logic [DATA_W-1:0] ch [NUM_CH];
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic [FW-1:0]     head;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            ch[i] = ch_data[i*DATA_W +: DATA_W];
        end
    end

    assign gnt_any  = |grants;
    assign gnt_idx  = onehot_idx(grants);
    assign gnt_data = ch[gnt_idx];

`ifdef GRANT_DATA_MUX_ONEHOT_CHECK_EN
    assign gnt_ok = ((grants & (grants - 1'b1)) == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err <= 1'b0;
        else if (gnt_any && !gnt_ok)
            err <= 1'b1;
    end
`else
    assign gnt_ok = 1'b1;
    assign err    = 1'b0;
`endif

    // accepted is combinational so the arbiter sees it on the capture edge.
    assign push     = gnt_any & gnt_ok & ~full;
    assign accepted = push;
    assign pop      = out_valid & out_ready;

    grant_mux_fifo #(
        .W     (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata ({gnt_idx, gnt_data}),
        .full  (full),
        .empty (empty),
        .head  (head)
    );

    assign out_valid           = ~empty;
    assign {out_src, out_data} = head;

endmodule

// File: tb/tb_grant_data_mux.sv
// Directed vector bench for grant_data_mux (DATA_W=8, DEPTH=4).
module tb_grant_data_mux;

    logic        clk;
    logic        rst_n;
    logic [3:0]  grants;
    logic [31:0] ch_data;
    logic        accepted;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_src;
    logic        err;

    int n_vec;
    int n_bad;

    grant_data_mux #(
        .DATA_W (8),
        .DEPTH  (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .grants    (grants),
        .ch_data   (ch_data),
        .accepted  (accepted),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_src   (out_src),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  g;
        logic [31:0] d;
        logic        rdy;
        logic        acc;
        logic        vld;
        logic [7:0]  dat;
        logic [1:0]  src;
    } vec_t;

    vec_t tbl [24];

    task automatic drive(input logic [3:0] g, input logic [31:0] d,
                         input logic rdy);
        @(negedge clk);
        grants    = g;
        ch_data   = d;
        out_ready = rdy;
        #1;
    endtask

    task automatic chk(input string nm, input logic e_acc,
                       input logic e_vld, input logic [7:0] e_dat,
                       input logic [1:0] e_src, input logic e_err);
        n_vec++;
        if (accepted !== e_acc) begin
            n_bad++;
            $display("FAIL %s: accepted=%0b want %0b", nm, accepted, e_acc);
        end
        if (out_valid !== e_vld) begin
            n_bad++;
            $display("FAIL %s: out_valid=%0b want %0b", nm, out_valid, e_vld);
        end
        if (out_data !== e_dat) begin
            n_bad++;
            $display("FAIL %s: out_data=%h want %h", nm, out_data, e_dat);
        end
        if (out_src !== e_src) begin
            n_bad++;
            $display("FAIL %s: out_src=%0d want %0d", nm, out_src, e_src);
        end
        if (err !== e_err) begin
            n_bad++;
            $display("FAIL %s: err=%0b want %0b", nm, err, e_err);
        end
    endtask

    logic [9:0]  q [$];
    logic [1:0]  c;
    logic [7:0]  b;
    logic [7:0]  e;
    logic [31:0] d;

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst_n = 1'b0;
        grants = '0;
        ch_data = '0;
        out_ready = 1'b0;

        // grant ch2 -> same-cycle accept, visible next cycle
        tbl[0]  = '{4'b0000, 32'h11A52233, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0};
        tbl[1]  = '{4'b0100, 32'h11A52233, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0};
        tbl[2]  = '{4'b0000, 32'h11A52233, 1'b0, 1'b0, 1'b1, 8'hA5, 2'd2};
        tbl[3]  = '{4'b0000, 32'h11A52233, 1'b1, 1'b0, 1'b1, 8'hA5, 2'd2};
        tbl[4]  = '{4'b0000, 32'h11A52233, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0};
        // fill 0,1,2,3 then ch1 waits for a pop
        tbl[5]  = '{4'b0001, 32'h44332211, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0};
        tbl[6]  = '{4'b0010, 32'h44332211, 1'b0, 1'b1, 1'b1, 8'h11, 2'd0};
        tbl[7]  = '{4'b0100, 32'h44332211, 1'b0, 1'b1, 1'b1, 8'h11, 2'd0};
        tbl[8]  = '{4'b1000, 32'h44332211, 1'b0, 1'b1, 1'b1, 8'h11, 2'd0};
        tbl[9]  = '{4'b0010, 32'h44332211, 1'b0, 1'b0, 1'b1, 8'h11, 2'd0};
        tbl[10] = '{4'b0010, 32'h44332211, 1'b1, 1'b0, 1'b1, 8'h11, 2'd0};
        tbl[11] = '{4'b0010, 32'h44332211, 1'b0, 1'b1, 1'b1, 8'h22, 2'd1};
        tbl[12] = '{4'b0000, 32'h44332211, 1'b1, 1'b0, 1'b1, 8'h22, 2'd1};
        tbl[13] = '{4'b0000, 32'h44332211, 1'b1, 1'b0, 1'b1, 8'h33, 2'd2};
        tbl[14] = '{4'b0000, 32'h44332211, 1'b1, 1'b0, 1'b1, 8'h44, 2'd3};
        tbl[15] = '{4'b0000, 32'h44332211, 1'b1, 1'b0, 1'b1, 8'h22, 2'd1};
        tbl[16] = '{4'b0000, 32'h44332211, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0};
        // push+pop at count=2
        tbl[17] = '{4'b0001, 32'hDDCCBBAA, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0};
        tbl[18] = '{4'b0010, 32'hDDCCBBAA, 1'b0, 1'b1, 1'b1, 8'hAA, 2'd0};
        tbl[19] = '{4'b0100, 32'hDDCCBBAA, 1'b1, 1'b1, 1'b1, 8'hAA, 2'd0};
        tbl[20] = '{4'b0000, 32'hDDCCBBAA, 1'b0, 1'b0, 1'b1, 8'hBB, 2'd1};
        tbl[21] = '{4'b0000, 32'hDDCCBBAA, 1'b1, 1'b0, 1'b1, 8'hBB, 2'd1};
        tbl[22] = '{4'b0000, 32'hDDCCBBAA, 1'b1, 1'b0, 1'b1, 8'hCC, 2'd2};
        tbl[23] = '{4'b0000, 32'hDDCCBBAA, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0};

        #1;
        chk("reset", 1'b0, 1'b0, 8'h00, 2'd0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 24; i++) begin
            drive(tbl[i].g, tbl[i].d, tbl[i].rdy);
            chk($sformatf("vec%0d", i), tbl[i].acc, tbl[i].vld,
                tbl[i].dat, tbl[i].src, 1'b0);
        end

        // pointer wrap against a reference queue
        for (int i = 0; i < 10; i++) begin
            c = 2'(i % 4);
            b = 8'(8'h40 + i * 16);
            d = {b + 8'd3, b + 8'd2, b + 8'd1, b};
            e = b + 8'(c);
            drive(4'b0001 << c, d, 1'b0);
            chk($sformatf("wrap_push%0d", i), 1'b1, 1'b0, 8'h00, 2'd0, 1'b0);
            q.push_back({c, e});
            drive(4'b0000, 32'h0, 1'b1);
            chk($sformatf("wrap_pop%0d", i), 1'b0, 1'b1,
                q[0][7:0], q[0][9:8], 1'b0);
            void'(q.pop_front());
        end
        drive(4'b0000, 32'h0, 1'b0);
        chk("wrap_empty", 1'b0, 1'b0, 8'h00, 2'd0, 1'b0);

        // non-one-hot grant
        drive(4'b0110, 32'h00007700, 1'b0);
`ifdef GRANT_DATA_MUX_ONEHOT_CHECK_EN
        chk("multi_grant", 1'b0, 1'b0, 8'h00, 2'd0, 1'b0);
        drive(4'b0000, 32'h0, 1'b0);
        chk("err_set", 1'b0, 1'b0, 8'h00, 2'd0, 1'b1);
        drive(4'b0000, 32'h0, 1'b0);
        drive(4'b0000, 32'h0, 1'b0);
        chk("err_sticky", 1'b0, 1'b0, 8'h00, 2'd0, 1'b1);
`else
        chk("multi_grant", 1'b1, 1'b0, 8'h00, 2'd0, 1'b0);
        drive(4'b0000, 32'h0, 1'b1);
        chk("multi_head", 1'b0, 1'b1, 8'h77, 2'd1, 1'b0);
        drive(4'b0000, 32'h0, 1'b0);
        chk("multi_empty", 1'b0, 1'b0, 8'h00, 2'd0, 1'b0);
`endif
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("err_clear", 1'b0, 1'b0, 8'h00, 2'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // reset with three entries queued
        drive(4'b0001, 32'h0C0B0A09, 1'b0);
        drive(4'b0010, 32'h0C0B0A09, 1'b0);
        drive(4'b0100, 32'h0C0B0A09, 1'b0);
        drive(4'b0000, 32'h0C0B0A09, 1'b0);
        chk("q3_head", 1'b0, 1'b1, 8'h09, 2'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_reset", 1'b0, 1'b0, 8'h00, 2'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_reset", 1'b0, 1'b0, 8'h00, 2'd0, 1'b0);
        drive(4'b1000, 32'h5E000000, 1'b0);
        chk("post_push", 1'b1, 1'b0, 8'h00, 2'd0, 1'b0);
        drive(4'b0000, 32'h0, 1'b1);
        chk("post_head", 1'b0, 1'b1, 8'h5E, 2'd3, 1'b0);
        drive(4'b0000, 32'h0, 1'b0);
        chk("post_empty", 1'b0, 1'b0, 8'h00, 2'd0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/grant_data_mux.md
# grant_data_mux

Consumer stage directly downstream of the 4-way round-robin arbiter. It watches the arbiter's one-hot `grants`, selects the granted channel's payload, and pushes the payload plus its source index into an output FIFO. It returns the `accepted` strobe that closes each grant. The FIFO drains through a valid/ready interface toward the shared sink.

## Interface
- `DATA_W`, 8: payload width per channel.
- `DEPTH`, 4: output FIFO entries; power of two, ≥2.
- `clk` input 1: clock, all state updates on rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `grants` input 4: one-hot grant from arbiter; all-zero means no grant.
- `ch_data` input 4*DATA_W: channel payloads; channel i occupies bits [i*DATA_W +: DATA_W].
- `accepted` output 1: grant consumed this cycle; fed back to the arbiter.
- `out_valid` output 1: FIFO head valid.
- `out_ready` input 1: sink takes head when `out_valid & out_ready`.
- `out_data` output DATA_W: FIFO head payload.
- `out_src` output 2: channel index of the head entry.
- `err` output 1: sticky grant-protocol error flag.

## Operation
- Grant decode:
  - `gnt_any = |grants`.
  - `gnt_idx` is the index of the set bit.
  - `gnt_ok` = one-hot grant (see Configuration).
- Push: `push = gnt_any & gnt_ok & ~full`. On push, FIFO writes {`gnt_idx`, `ch_data[gnt_idx]`} at the write pointer.
- `accepted = push`. It is combinational from `grants`/`full`, so the arbiter samples it on the same edge the FIFO captures.
- The arbiter drops `grants` the cycle after `accepted`, so exactly one push occurs per grant. A grant held while `full` stays pending, and `accepted` stays 0 until a pop frees space.
- Pop: `pop = out_valid & out_ready`. The read pointer advances and the count decrements.
- FIFO state:
  - `wr_ptr` and `rd_ptr` are log2(DEPTH) bits and wrap DEPTH-1→0.
  - `count` is log2(DEPTH)+1 bits, range 0..DEPTH.
  - `full = (count==DEPTH)`, `empty = (count==0)`, `out_valid = ~empty`.
- Simultaneous push and pop (only possible when not full and not empty): both pointers advance and `count` is unchanged.
- Full: no push; a pop in that cycle frees the slot, and the push waits until the next cycle. There is no pass-through while full.
- Empty: `out_valid=0`, and `out_data`/`out_src` are driven 0 (masked). There is no bypass: a pushed entry is visible the cycle after the push.
- `err` is set by a protocol violation and cleared only by reset.

## Timing
- Reset values: `out_valid=0`, `out_data=0`, `out_src=0`, `err=0`. `accepted` is 0 whenever `grants==0`.
- Pointers and `count` reset to 0, and stored FIFO contents are don't-care.
- Grant→accepted latency: 0 cycles when not full.
- Push→`out_valid` latency: 1 cycle.
- With a free-running sink, throughput is bounded by the arbiter cycle: at least 3 cycles per grant.
- Reset asserted mid-operation clears the FIFO immediately. Queued entries are lost and `accepted` drops with `grants`.

## Configuration
- Macro: `GRANT_DATA_MUX_ONEHOT_CHECK_EN`.
- Defined:
  - `gnt_ok = (grants & (grants-1))==0`.
  - A non-one-hot, non-zero `grants` gives no push and `accepted=0`, and sets `err` on the next edge.
- Undefined:
  - `gnt_ok=1`.
  - `gnt_idx` is the lowest-index set bit.
  - `err` is tied to 0.

## Structure
- Package `grant_data_mux_pkg` holds:
  - `NUM_CH=4`.
  - `SRC_W=2`.
  - Typedef `src_t` (SRC_W bits).
  - Function `onehot_idx` (lowest-set-bit encoder).
- Sub-module `grant_mux_fifo` is a synchronous FIFO parameterised by width (DATA_W+SRC_W) and DEPTH. It exposes push, pop, full, empty, and head.
- The top level holds grant decode, payload mux, `accepted`, and `err`.

## Test plan
- Reset, then `grants=4'b0100`, `ch_data` chan2=0xA5: `accepted=1` in the same cycle. Next cycle `out_valid=1`, `out_data=0xA5`, `out_src=2`.
- `out_ready=0`, four grants on channels 0,1,2,3 → FIFO full. A fifth grant on ch1 holds `accepted=0`. Popping one entry gives `accepted=1` the cycle after the pop. Drain order is 0,1,2,3,1.
- Push and pop in the same cycle at count=2: `count` stays 2 and order is preserved.
- Wrap: 10 sequential push/pop pairs on DEPTH=4. Data matches the reference queue across the pointer wrap.
- With the macro defined, `grants=4'b0110`: `accepted=0`, no push, `err=1` next cycle and sticky until `rst_n=0`. With the macro undefined, the same input pushes chan1 data with `out_src=1` and `err=0`.
- Assert `rst_n=0` with 3 entries queued: `out_valid=0` and `out_data=0` immediately, and the FIFO is empty after release.
